// File: rtl/bullet_slot_ctrl.sv
// Per-tank shot scheduler: fire presses become one-cycle create pulses on the lowest free bullet slot,
// with cooldown, per-slot lifetime and hit release. Define BULLET_AUTO_FIRE_EN for held-key auto-fire.
module bullet_slot_ctrl #(
  parameter int NUM_SLOTS       = 3,
  parameter int LIFE_FRAMES     = 240,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  input  logic                 enable,
  input  logic                 fire,
  input  logic [NUM_SLOTS-1:0] hit,
  output logic [NUM_SLOTS-1:0] create,
  output logic [NUM_SLOTS-1:0] slot_live,
  output logic [2:0]           free_count,
  output logic                 shot_fired
);

  localparam int LW = (LIFE_FRAMES > 1)     ? $clog2(LIFE_FRAMES)     : 1;
  localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam int SW = (NUM_SLOTS > 1)       ? $clog2(NUM_SLOTS)       : 1;

  localparam logic [LW-1:0] LIFE_INIT = LW'(LIFE_FRAMES - 1);
  localparam logic [CW-1:0] CD_INIT   = CW'(COOLDOWN_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    COOLDOWN,
    WAIT_RELEASE
  } state_t;

  state_t          state, state_nxt;
  logic            fire_q;
  logic            start;
  logic            any_free;
  logic [SW-1:0]   sel, sel_nxt, free_sel;
  logic [CW-1:0]   cd, cd_nxt;
  logic [LW-1:0]   life [NUM_SLOTS];
  logic [2:0]      live_cnt;

  always_comb begin
    live_cnt = '0;
    free_sel = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      live_cnt = live_cnt + 3'(slot_live[i]);
      if (!slot_live[i]) free_sel = SW'(i);
    end
  end

  assign free_count = 3'(NUM_SLOTS) - live_cnt;
  assign any_free   = (free_count != 3'd0);

`ifdef BULLET_AUTO_FIRE_EN
  assign start = fire & enable & any_free;
`else
  logic fire_rise;
  assign fire_rise = fire & ~fire_q;
  assign start     = fire_rise & enable & any_free;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt  = state;
    sel_nxt    = sel;
    cd_nxt     = cd;
    create     = '0;
    shot_fired = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FIRE;
          sel_nxt   = free_sel;
        end
      end
      FIRE: begin
        create     = NUM_SLOTS'(1) << sel;
        shot_fired = 1'b1;
        cd_nxt     = CD_INIT;
        state_nxt  = COOLDOWN;
      end
      COOLDOWN: begin
        if (cd != '0) begin
          cd_nxt = cd - 1'b1;
        end else begin
`ifdef BULLET_AUTO_FIRE_EN
          if (start) begin
            state_nxt = FIRE;
            sel_nxt   = free_sel;
          end else begin
            state_nxt = IDLE;
          end
`else
          state_nxt = fire ? WAIT_RELEASE : IDLE;
`endif
        end
      end
      WAIT_RELEASE: begin
        if (!fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Round stopped: abort whatever is in flight, including a FIRE about to land.
    if (!enable) begin
      state_nxt = IDLE;
      cd_nxt    = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      sel    <= '0;
      cd     <= '0;
      fire_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      cd     <= cd_nxt;
      fire_q <= fire;
    end
  end

  // A launch into slot sel overrides a stale hit on it; other slots expire or get hit in parallel.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      slot_live <= '0;
      // NOTE: the life counters are a handful of flops, not a RAM, so resetting them is cheap and keeps them deterministic.
      for (int k = 0; k < NUM_SLOTS; k++) life[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (!enable) begin
          slot_live[k] <= 1'b0;
          life[k]      <= '0;
        end else if (state == FIRE && sel == SW'(k)) begin
          slot_live[k] <= 1'b1;
          life[k]      <= LIFE_INIT;
        end else if (slot_live[k]) begin
          if (hit[k] || life[k] == '0) begin
            slot_live[k] <= 1'b0;
            life[k]      <= '0;
          end else begin
            life[k] <= life[k] - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bullet_slot_ctrl.sv
// Scoreboard bench for bullet_slot_ctrl (default build): stimulus pushes expected create vectors,
// a negedge monitor pops and compares every create/shot_fired pulse the DUT emits.
module tb_bullet_slot_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset_n;
  logic       enable;
  logic       fire;
  logic [2:0] hit;
  logic [2:0] create;
  logic [2:0] slot_live;
  logic [2:0] free_count;
  logic       shot_fired;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] sb_q [$];

  bullet_slot_ctrl #(
    .NUM_SLOTS      (3),
    .LIFE_FRAMES    (240),
    .COOLDOWN_FRAMES(15)
  ) dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .enable    (enable),
    .fire      (fire),
    .hit       (hit),
    .create    (create),
    .slot_live (slot_live),
    .free_count(free_count),
    .shot_fired(shot_fired)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  // One-cycle press; exp is the create vector it must produce, or 0 if it must be dropped.
  task automatic press(input logic [2:0] exp);
    fire = 1'b1;
    if (exp != 3'b000) sb_q.push_back(exp);
    tick(1);
    fire = 1'b0;
  endtask

  // Monitor: every cycle carrying a pulse must match the oldest expected launch.
  initial begin
    logic [2:0] exp_c;
    forever begin
      @(negedge frame_clk);
      if (create != 3'b000 || shot_fired) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_create: got create=%b shot_fired=%b, expected no pulse",
                   create, shot_fired);
        end else begin
          exp_c = sb_q.pop_front();
          if (create !== exp_c || shot_fired !== 1'b1) begin
            n_err++;
            $display("FAIL create_pulse: got create=%b shot_fired=%b, expected create=%b shot_fired=1",
                     create, shot_fired, exp_c);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    Reset_n = 1'b0;
    enable  = 1'b1;
    fire    = 1'b0;
    hit     = 3'b000;
    tick(3);
    check("reset_slot_live", 32'(slot_live), 32'h0);
    check("reset_free_count", 32'(free_count), 32'd3);
    check("reset_create", 32'(create), 32'h0);
    check("reset_shot_fired", 32'(shot_fired), 32'h0);
    Reset_n = 1'b1;
    tick(4);

    // First shot: create in the FIRE cycle, slot_live one edge later.
    press(3'b001);
    check("t1_live_not_yet", 32'(slot_live), 32'h0);
    tick(1);
    check("t1_slot_live", 32'(slot_live), 32'b001);
    check("t1_free_count", 32'(free_count), 32'd2);

    // Fill remaining slots in order, then a press with no free slot is dropped.
    tick(20);
    press(3'b010);
    tick(20);
    press(3'b100);
    tick(1);
    check("t2_all_live", 32'(slot_live), 32'b111);
    check("t2_free_zero", 32'(free_count), 32'd0);
    tick(20);
    press(3'b000);
    tick(3);
    check("t2_full_free", 32'(free_count), 32'd0);
    check("t2_sb_drained", 32'(sb_q.size()), 32'd0);

    // Hit frees slot 0; the next press reuses the lowest free slot.
    hit = 3'b001;
    tick(1);
    hit = 3'b000;
    check("t5_after_hit", 32'(slot_live), 32'b110);
    check("t5_free_one", 32'(free_count), 32'd1);
    press(3'b001);
    tick(1);
    check("t5_refilled", 32'(slot_live), 32'b111);
    hit = 3'b110;
    tick(1);
    hit = 3'b000;
    check("t5_multi_hit", 32'(slot_live), 32'b001);
    check("t5_multi_free", 32'(free_count), 32'd2);

    // Async reset mid-COOLDOWN with two slots live.
    tick(17);
    press(3'b010);
    tick(4);
    check("t6_two_live", 32'(slot_live), 32'b011);
    Reset_n = 1'b0;
    #1;
    check("t6_rst_live", 32'(slot_live), 32'h0);
    check("t6_rst_free", 32'(free_count), 32'd3);
    check("t6_rst_create", 32'(create), 32'h0);
    tick(2);
    Reset_n = 1'b1;
    tick(2);
    press(3'b001);
    tick(1);
    check("t6_post_reset_shot", 32'(slot_live), 32'b001);

    // Holding fire for 100 cycles gives exactly one shot.
    tick(17);
    fire = 1'b1;
    sb_q.push_back(3'b010);
    tick(100);
    fire = 1'b0;
    tick(2);
    check("t3_hold_live", 32'(slot_live), 32'b011);
    check("t3_hold_free", 32'(free_count), 32'd1);
    check("t3_sb_drained", 32'(sb_q.size()), 32'd0);

    // enable dropped during FIRE aborts the shot; re-enable with fire held does not fire.
    fire = 1'b1;
    sb_q.push_back(3'b100);
    tick(1);
    enable = 1'b0;
    tick(1);
    check("t7_create_cleared", 32'(create), 32'h0);
    check("t7_live_cleared", 32'(slot_live), 32'h0);
    check("t7_free_all", 32'(free_count), 32'd3);
    tick(2);
    enable = 1'b1;
    tick(4);
    check("t7_reenable_held", 32'(slot_live), 32'h0);
    fire = 1'b0;
    tick(2);

    // Lifetime: a stale hit on the FIRE slot loses, a hit on dead slots is ignored,
    // and the bullet stays live exactly 240 cycles.
    press(3'b001);
    hit = 3'b001;
    tick(1);
    hit = 3'b000;
    cnt = 0;
    while (slot_live[0] && cnt < 300) begin
      cnt++;
      hit = (cnt == 10) ? 3'b110 : 3'b000;
      tick(1);
    end
    hit = 3'b000;
    check("t4_life_cycles", 32'(cnt), 32'd240);
    check("t4_expired_live", 32'(slot_live), 32'h0);
    check("t4_expired_free", 32'(free_count), 32'd3);

    tick(5);
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
